// File: rtl/ula_pkg.sv
// Shared constants for the 8-bit 74181-style ALU.
// Function codes and mode values used by the overflow logic and the core.
package ula_pkg;

    localparam logic [3:0] S_ADD   = 4'b1001;
    localparam logic [3:0] S_SUB   = 4'b0110;
    localparam logic       M_LOGIC = 1'b1;
    localparam logic       M_ARITH = 1'b0;

endpackage

// File: rtl/ula_slice_4bit.sv
// Combinational 4-bit 74181-style slice.
// Gives 16 logic and 16 arithmetic functions plus lookahead flags.
module ula_slice_4bit
    import ula_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f,
    output logic       a_eq_b,
    output logic       c_out,
    output logic       p,
    output logic       g
);

    logic [3:0] w_o;
    logic [3:0] w_n;
    logic [4:0] w_c;

    always_comb begin
        w_o = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        w_n = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    end

    // N implies O per bit, so N is the bit generate and O the propagate
    always_comb begin
        w_c    = '0;
        w_c[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            w_c[i+1] = w_n[i] | (w_o[i] & w_c[i]);
        end
    end

    always_comb begin
        if (m == M_LOGIC) begin
            f = ~(w_o ^ w_n);
        end else begin
            f = w_o ^ w_n ^ w_c[3:0];
        end
    end

    assign p      = &w_o;
    assign g      = w_n[3]
                  | (w_o[3] & w_n[2])
                  | (w_o[3] & w_o[2] & w_n[1])
                  | (w_o[3] & w_o[2] & w_o[1] & w_n[0]);
    assign c_out  = g | (p & c_in);
    assign a_eq_b = &f;

endmodule

// File: rtl/ula_8bit.sv
// 8-bit ALU: two rippled 74181-style slices with registered outputs.
// Adds signed overflow for add/subtract and 8-bit group P/G.
module ula_8bit
    import ula_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [7:0] f,
    output logic       a_eq_b,
    output logic       c_out,
    output logic       overflow,
    output logic       p,
    output logic       g
);

    logic [3:0] w_f_lo;
    logic [3:0] w_f_hi;
    logic       w_eq_lo;
    logic       w_eq_hi;
    logic       w_c_lo;
    logic       w_c_hi;
    logic       w_p_lo;
    logic       w_p_hi;
    logic       w_g_lo;
    logic       w_g_hi;
    logic [7:0] w_f;
    logic       w_p;
    logic       w_g;
    logic       w_ovf;

    ula_slice_4bit u_lo (
        .a      (a[3:0]),
        .b      (b[3:0]),
        .s      (s),
        .m      (m),
        .c_in   (c_in),
        .f      (w_f_lo),
        .a_eq_b (w_eq_lo),
        .c_out  (w_c_lo),
        .p      (w_p_lo),
        .g      (w_g_lo)
    );

    ula_slice_4bit u_hi (
        .a      (a[7:4]),
        .b      (b[7:4]),
        .s      (s),
        .m      (m),
        .c_in   (w_c_lo),
        .f      (w_f_hi),
        .a_eq_b (w_eq_hi),
        .c_out  (w_c_hi),
        .p      (w_p_hi),
        .g      (w_g_hi)
    );

    assign w_f = {w_f_hi, w_f_lo};
    assign w_p = w_p_lo & w_p_hi;
    assign w_g = w_g_hi | (w_p_hi & w_g_lo);

    always_comb begin
        w_ovf = 1'b0;
        if (m == M_ARITH && s == S_ADD) begin
            w_ovf = (a[7] == b[7]) && (w_f[7] != a[7]);
        end else if (m == M_ARITH && s == S_SUB) begin
            w_ovf = (a[7] != b[7]) && (w_f[7] == b[7]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f        <= '0;
            a_eq_b   <= 1'b0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            p        <= 1'b0;
            g        <= 1'b0;
        end else begin
            f        <= w_f;
            a_eq_b   <= w_eq_lo & w_eq_hi;
            c_out    <= w_c_hi;
            overflow <= w_ovf;
            p        <= w_p;
            g        <= w_g;
        end
    end

endmodule

// File: tb/tb_ula_8bit.sv
// Directed and swept checks of ula_8bit against hand values
// and an independent function-table golden model.
module tb_ula_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
    logic       m;
    logic       c_in;
    logic [7:0] f;
    logic       a_eq_b;
    logic       c_out;
    logic       overflow;
    logic       p;
    logic       g;

    int n_chk;
    int n_err;

    ula_8bit dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .s        (s),
        .m        (m),
        .c_in     (c_in),
        .f        (f),
        .a_eq_b   (a_eq_b),
        .c_out    (c_out),
        .overflow (overflow),
        .p        (p),
        .g        (g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] mode_cin, input logic [3:0] fs,
                         input logic [7:0] va, input logic [7:0] vb);
        m    = mode_cin[1];
        c_in = mode_cin[0];
        s    = fs;
        a    = va;
        b    = vb;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] logic_fn(input logic [3:0] fs,
                                            input logic [7:0] x,
                                            input logic [7:0] y);
        logic [7:0] r;
        case (fs)
            4'h0: r = ~x;
            4'h1: r = ~(x | y);
            4'h2: r = ~x & y;
            4'h3: r = 8'h00;
            4'h4: r = ~(x & y);
            4'h5: r = ~y;
            4'h6: r = x ^ y;
            4'h7: r = x & ~y;
            4'h8: r = ~x | y;
            4'h9: r = ~(x ^ y);
            4'hA: r = y;
            4'hB: r = x & y;
            4'hC: r = 8'hFF;
            4'hD: r = x | ~y;
            4'hE: r = x | y;
            default: r = x;
        endcase
        return r;
    endfunction

    task automatic sweep_one(input logic mm, input logic [3:0] fs,
                             input logic ci, input logic [7:0] va,
                             input logic [7:0] vb);
        logic [7:0] o;
        logic [7:0] n;
        logic [8:0] sum;
        logic [8:0] gen;
        logic [7:0] ef;
        logic       eo;
        o   = va | (vb & {8{fs[0]}}) | (~vb & {8{fs[1]}});
        n   = (va & ~vb & {8{fs[2]}}) | (va & vb & {8{fs[3]}});
        sum = {1'b0, o} + {1'b0, n} + {8'd0, ci};
        gen = {1'b0, o} + {1'b0, n};
        ef  = mm ? logic_fn(fs, va, vb) : sum[7:0];
        eo  = 1'b0;
        if (!mm && fs == 4'b1001) eo = (va[7] == vb[7]) && (ef[7] != va[7]);
        if (!mm && fs == 4'b0110) eo = (va[7] != vb[7]) && (ef[7] == vb[7]);
        drive({mm, ci}, fs, va, vb);
        chk("sw_f",   f,                 ef);
        chk("sw_eq",  {7'd0, a_eq_b},    {7'd0, &ef});
        chk("sw_co",  {7'd0, c_out},     {7'd0, sum[8]});
        chk("sw_ovf", {7'd0, overflow},  {7'd0, eo});
        chk("sw_p",   {7'd0, p},         {7'd0, &o});
        chk("sw_g",   {7'd0, g},         {7'd0, gen[8]});
    endtask

    logic [7:0] pa [6];
    logic [7:0] pb [6];

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        a = 8'h5A; b = 8'h3C; s = 4'b1001; m = 1'b0; c_in = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_f",   f,                8'h00);
        chk("rst_flg", {2'd0, a_eq_b, c_out, overflow, p, g, 1'b0}, 8'h00);
        rst = 1'b0;

        drive(2'b00, 4'b1001, 8'h0F, 8'h01);
        chk("add_0f_f",   f,                 8'h10);
        chk("add_0f_co",  {7'd0, c_out},     8'h00);
        chk("add_0f_ovf", {7'd0, overflow},  8'h00);

        drive(2'b00, 4'b1001, 8'h7F, 8'h01);
        chk("add_7f_f",   f,                 8'h80);
        chk("add_7f_ovf", {7'd0, overflow},  8'h01);
        chk("add_7f_co",  {7'd0, c_out},     8'h00);

        drive(2'b00, 4'b1001, 8'h80, 8'h80);
        chk("add_80_f",   f,                 8'h00);
        chk("add_80_co",  {7'd0, c_out},     8'h01);
        chk("add_80_ovf", {7'd0, overflow},  8'h01);

        drive(2'b01, 4'b0110, 8'h80, 8'h01);
        chk("sub_80_f",   f,                 8'h7F);
        chk("sub_80_ovf", {7'd0, overflow},  8'h01);
        chk("sub_80_co",  {7'd0, c_out},     8'h01);

        drive(2'b00, 4'b0110, 8'h55, 8'h55);
        chk("sub_55_f",   f,                 8'hFF);
        chk("sub_55_flg", {3'd0, a_eq_b, p, g, c_out, overflow}, 8'h18);

        drive(2'b10, 4'b0110, 8'hAA, 8'h55);
        chk("lx_f",   f,                8'hFF);
        chk("lx_ovf", {7'd0, overflow}, 8'h00);

        drive(2'b10, 4'b0000, 8'h0F, 8'h00);
        chk("lnot_f",   f,                8'hF0);
        chk("lnot_ovf", {7'd0, overflow}, 8'h00);

        drive(2'b10, 4'b1011, 8'h0F, 8'hF0);
        chk("land_f",   f,                8'h00);
        chk("land_ovf", {7'd0, overflow}, 8'h00);

        // reset must win over a live operation
        rst = 1'b1;
        drive(2'b00, 4'b1001, 8'hFF, 8'hFF);
        chk("rst2_f",   f,                8'h00);
        chk("rst2_flg", {3'd0, a_eq_b, c_out, overflow, p, g}, 8'h00);
        rst = 1'b0;

        pa[0] = 8'h00; pb[0] = 8'h00;
        pa[1] = 8'hFF; pb[1] = 8'h00;
        pa[2] = 8'h00; pb[2] = 8'hFF;
        pa[3] = 8'hAA; pb[3] = 8'h55;
        pa[4] = 8'h0F; pb[4] = 8'hF0;
        pa[5] = 8'hFF; pb[5] = 8'hFF;
        for (int mi = 0; mi < 2; mi++) begin
            for (int si = 0; si < 16; si++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    for (int k = 0; k < 6; k++) begin
                        sweep_one(mi[0], si[3:0], ci[0], pa[k], pb[k]);
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
